// File: rtl/ppi_kbd_scan_ctrl.sv
// ppi_kbd_scan_ctrl
// Owns the i8255 CPU-side bus, scans a keyboard matrix (column drive on
// port A, row sense on port B) into a double-buffered image, and arbitrates
// host CPU accesses onto the same bus with priority over the scanner.
//
// Ports:
//   i_clk, i_reset                 clock, synchronous active-high reset
//   i_scan_en                      enables periodic scanning
//   i_cpu_req/we/addr/wdata        CPU access request (held until ack)
//   o_cpu_ack, o_cpu_rdata         completion pulse and read data
//   o_ppi_cs_n/rd_n/wr_n/addr/data registered i8255 bus outputs
//   i_ppi_data                     i8255 read data (valid in DONE cycle)
//   i_mat_col, o_mat_row           committed matrix read port
//   o_any_key                      OR of the committed matrix
//   o_scan_done                    one-cycle pulse on scan commit
module ppi_kbd_scan_ctrl #(
  parameter int unsigned COLS     = 8,
  parameter int unsigned SETTLE   = 3,
  parameter int unsigned SCAN_GAP = 1024
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_scan_en,
  input  logic       i_cpu_req,
  input  logic       i_cpu_we,
  input  logic [1:0] i_cpu_addr,
  input  logic [7:0] i_cpu_wdata,
  output logic       o_cpu_ack,
  output logic [7:0] o_cpu_rdata,
  output logic       o_ppi_cs_n,
  output logic       o_ppi_rd_n,
  output logic       o_ppi_wr_n,
  output logic [1:0] o_ppi_addr,
  output logic [7:0] o_ppi_data,
  input  logic [7:0] i_ppi_data,
  input  logic [2:0] i_mat_col,
  output logic [7:0] o_mat_row,
  output logic       o_any_key,
  output logic       o_scan_done
);

  localparam int unsigned SET_W = $clog2(SETTLE + 1);
  localparam int unsigned GAP_W = $clog2(SCAN_GAP + 1);
  localparam logic [7:0]  CTRL_WORD = 8'h8B;

  typedef enum logic [2:0] {
    S_INIT, S_WAIT_GAP, S_WR_COL, S_SETTLE, S_RD_ROW, S_NEXT, S_RELEASE, S_COMMIT
  } scan_state_t;

  typedef enum logic [1:0] {B_IDLE, B_STROBE, B_DONE} bus_phase_t;

  scan_state_t      state_q, state_d;
  bus_phase_t       phase_q, phase_d;
  logic             owner_cpu_q, acc_we_q;
  logic [2:0]       col_q, acc_col_q;
  logic [SET_W-1:0] settle_cnt_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic             skip_gap_q;
  logic [7:0]       shadow_q [8];
  logic [7:0]       matrix_q [8];
  logic             cpu_ack_q;
  logic [7:0]       rdata_q;

  logic       bus_free, grant_cpu, grant_scan;
  logic       scan_req, scan_we;
  logic [1:0] scan_addr;
  logic [7:0] scan_wdata;
  logic       acc_we_d;
  logic [1:0] acc_addr_d;
  logic [7:0] acc_wdata_d;
  logic       scan_owned_done, scan_rd_done, in_scan, abort, last_col;

  // Scanner bus request and CPU-priority arbitration
  always_comb begin
    scan_req   = 1'b0;
    scan_we    = 1'b1;
    scan_addr  = 2'd0;
    scan_wdata = 8'hFF;
    case (state_q)
      S_INIT: begin
        scan_req   = 1'b1;
        scan_addr  = 2'd3;
        scan_wdata = CTRL_WORD;
      end
      S_WR_COL: begin
        scan_req   = 1'b1;
        scan_wdata = ~(8'd1 << col_q);
      end
      S_RD_ROW: begin
        scan_req  = 1'b1;
        scan_we   = 1'b0;
        scan_addr = 2'd1;
      end
      S_RELEASE: scan_req = 1'b1;
      default: ;
    endcase

    bus_free = (phase_q != B_STROBE);
    // A CPU request still held during its own ack cycle must not re-grant
    grant_cpu  = bus_free && i_cpu_req && !(phase_q == B_DONE && owner_cpu_q);
    grant_scan = bus_free && scan_req && !grant_cpu;

    acc_we_d    = grant_cpu ? i_cpu_we    : scan_we;
    acc_addr_d  = grant_cpu ? i_cpu_addr  : scan_addr;
    acc_wdata_d = grant_cpu ? i_cpu_wdata : scan_wdata;

    scan_owned_done = (phase_q == B_DONE) && !owner_cpu_q;
    scan_rd_done    = scan_owned_done && !acc_we_q;
    in_scan  = state_q inside {S_WR_COL, S_SETTLE, S_RD_ROW, S_NEXT, S_RELEASE};
    // CPU rewriting port A or the control word invalidates the scan in flight
    abort    = grant_cpu && i_cpu_we && (i_cpu_addr == 2'd0 || i_cpu_addr == 2'd3) && in_scan;
    last_col = (col_q == 3'(COLS - 1));
  end

  // Bus phase state register
  always_ff @(posedge i_clk) begin
    if (i_reset) phase_q <= B_IDLE;
    else         phase_q <= phase_d;
  end

  // Bus phase next state: STROBE then DONE, back-to-back grants allowed from DONE
  always_comb begin
    phase_d = phase_q;
    case (phase_q)
      B_IDLE, B_DONE: phase_d = (grant_cpu || grant_scan) ? B_STROBE : B_IDLE;
      B_STROBE:       phase_d = B_DONE;
      default:        phase_d = B_IDLE;
    endcase
  end

  // Scanner state register
  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= S_INIT;
    else         state_q <= state_d;
  end

  // Scanner next state; states requesting the bus advance when granted
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:     if (grant_scan) state_d = S_WAIT_GAP;
      S_WAIT_GAP: if (i_scan_en && (skip_gap_q || gap_cnt_q == '0)) state_d = S_WR_COL;
      S_WR_COL:   if (grant_scan) state_d = S_SETTLE;
      S_SETTLE:   if (settle_cnt_q == '0) state_d = S_RD_ROW;
      S_RD_ROW:   if (grant_scan) state_d = S_NEXT;
      S_NEXT:     state_d = last_col ? S_RELEASE : S_WR_COL;
      S_RELEASE:  if (grant_scan) state_d = S_COMMIT;
      S_COMMIT:   if (scan_owned_done) state_d = S_WAIT_GAP;
      default:    state_d = S_INIT;
    endcase
    if (abort) state_d = S_INIT;
  end

  // Bus outputs, CPU ack and read-data hold
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_ppi_cs_n  <= 1'b1;
      o_ppi_rd_n  <= 1'b1;
      o_ppi_wr_n  <= 1'b1;
      o_ppi_addr  <= 2'd0;
      o_ppi_data  <= 8'd0;
      owner_cpu_q <= 1'b0;
      acc_we_q    <= 1'b0;
      cpu_ack_q   <= 1'b0;
      rdata_q     <= 8'd0;
    end else begin
      cpu_ack_q <= 1'b0;
      if (grant_cpu || grant_scan) begin
        o_ppi_cs_n  <= 1'b0;
        o_ppi_rd_n  <= acc_we_d;
        o_ppi_wr_n  <= !acc_we_d;
        o_ppi_addr  <= acc_addr_d;
        if (acc_we_d) o_ppi_data <= acc_wdata_d;
        owner_cpu_q <= grant_cpu;
        acc_we_q    <= acc_we_d;
      end else begin
        o_ppi_cs_n <= 1'b1;
        o_ppi_rd_n <= 1'b1;
        o_ppi_wr_n <= 1'b1;
        if (phase_q == B_STROBE) cpu_ack_q <= owner_cpu_q;
      end
      if (cpu_ack_q && !acc_we_q) rdata_q <= i_ppi_data;
    end
  end

  // Scanner datapath: counters, column index, shadow and committed image
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      col_q        <= 3'd0;
      acc_col_q    <= 3'd0;
      settle_cnt_q <= '0;
      gap_cnt_q    <= '0;
      skip_gap_q   <= 1'b1;
      shadow_q     <= '{default: 8'd0};
      matrix_q     <= '{default: 8'd0};
      o_scan_done  <= 1'b0;
    end else begin
      o_scan_done <= 1'b0;

      if (state_q == S_WR_COL && grant_scan)
        settle_cnt_q <= SET_W'(SETTLE);
      else if (state_q == S_SETTLE && settle_cnt_q != '0)
        settle_cnt_q <= settle_cnt_q - SET_W'(1);

      if (state_q == S_COMMIT && scan_owned_done)
        gap_cnt_q <= GAP_W'(SCAN_GAP - 1);
      else if (state_q == S_WAIT_GAP && gap_cnt_q != '0)
        gap_cnt_q <= gap_cnt_q - GAP_W'(1);

      if (state_q == S_WAIT_GAP && state_d == S_WR_COL) skip_gap_q <= 1'b0;
      if (state_q == S_RD_ROW && grant_scan) acc_col_q <= col_q;
      if (state_q == S_NEXT) col_q <= last_col ? 3'd0 : col_q + 3'd1;

      // Rows are active-low on port B; store 1 = pressed
      if (scan_rd_done) shadow_q[acc_col_q] <= ~i_ppi_data;

      if (state_q == S_COMMIT && scan_owned_done) begin
        matrix_q    <= shadow_q;
        o_scan_done <= 1'b1;
      end

      if (abort) begin
        col_q      <= 3'd0;
        skip_gap_q <= 1'b1;
        shadow_q   <= '{default: 8'd0};
      end
    end
  end

  // Read data is presented combinationally in the ack cycle, held afterwards
  assign o_cpu_ack   = cpu_ack_q;
  assign o_cpu_rdata = (cpu_ack_q && !acc_we_q) ? i_ppi_data : rdata_q;
  assign o_mat_row   = matrix_q[i_mat_col];

  always_comb begin
    o_any_key = 1'b0;
    for (int i = 0; i < 8; i++) o_any_key = o_any_key | (|matrix_q[i]);
  end

endmodule

// File: tb/tb_ppi_kbd_scan_ctrl.sv
`timescale 1ns/1ps
module tb_ppi_kbd_scan_ctrl;

  localparam int unsigned COLS     = 8;
  localparam int unsigned SETTLE   = 3;
  localparam int unsigned SCAN_GAP = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       scan_en;
  logic       cpu_req, cpu_we;
  logic [1:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_ack;
  logic [7:0] cpu_rdata;
  logic       cs_n, rd_n, wr_n;
  logic [1:0] ppi_addr;
  logic [7:0] ppi_wdata;
  logic [7:0] m_rdata;
  logic [2:0] mat_col;
  logic [7:0] mat_row;
  logic       any_key, scan_done;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  logic [7:0] keys [8];
  logic [7:0] pc_init;
  logic [7:0] m_pa, m_pc;

  always #5 clk = ~clk;

  ppi_kbd_scan_ctrl #(.COLS(COLS), .SETTLE(SETTLE), .SCAN_GAP(SCAN_GAP)) dut (
    .i_clk(clk), .i_reset(rst), .i_scan_en(scan_en),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_ack(cpu_ack), .o_cpu_rdata(cpu_rdata),
    .o_ppi_cs_n(cs_n), .o_ppi_rd_n(rd_n), .o_ppi_wr_n(wr_n),
    .o_ppi_addr(ppi_addr), .o_ppi_data(ppi_wdata), .i_ppi_data(m_rdata),
    .i_mat_col(mat_col), .o_mat_row(mat_row), .o_any_key(any_key), .o_scan_done(scan_done)
  );

  // Port B rows: a row reads low when a pressed key sits in any low-driven column
  function automatic logic [7:0] pb_of(input logic [7:0] pa_v);
    logic [7:0] r;
    r = 8'h00;
    for (int c = 0; c < 8; c++) if (!pa_v[c]) r = r | keys[c];
    return ~r;
  endfunction

  // i8255 model: registered read data, valid the cycle after the strobe
  always @(posedge clk) begin
    if (rst) begin
      m_pa    <= 8'hFF;
      m_pc    <= pc_init;
      m_rdata <= 8'h00;
    end else begin
      if (!cs_n && !wr_n) begin
        case (ppi_addr)
          2'd0: m_pa <= ppi_wdata;
          2'd2: m_pc <= ppi_wdata;
          default: ;
        endcase
      end
      if (!cs_n && !rd_n) begin
        case (ppi_addr)
          2'd0: m_rdata <= m_pa;
          2'd1: m_rdata <= pb_of(m_pa);
          2'd2: m_rdata <= m_pc;
          default: m_rdata <= 8'hFF;
        endcase
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Leaves the bench in the cycle before the first post-reset edge (cyc = -1)
  task automatic do_reset();
    rst = 1'b1;
    cpu_req = 1'b0;
    cpu_we = 1'b0;
    cpu_addr = 2'd0;
    cpu_wdata = 8'h00;
    repeat (3) step();
    rst = 1'b0;
    cyc = -1;
  endtask

  task automatic set_keys(input int col, input logic [7:0] rows);
    for (int c = 0; c < 8; c++) keys[c] = 8'h00;
    if (col >= 0) keys[col] = rows;
  endtask

  task automatic test_reset();
    set_keys(-1, 8'h00);
    scan_en = 1'b1;
    mat_col = 3'd0;
    rst = 1'b1;
    cpu_req = 1'b0;
    repeat (3) step();
    n_checks++;
    if ({cs_n, rd_n, wr_n} !== 3'b111) begin
      n_fails++; $display("FAIL reset_strobes: got %b expected 111", {cs_n, rd_n, wr_n});
    end
    n_checks++;
    if ({ppi_addr, ppi_wdata} !== 10'd0) begin
      n_fails++; $display("FAIL reset_addr_data: got %h/%h expected 0/00", ppi_addr, ppi_wdata);
    end
    n_checks++;
    if ({cpu_ack, scan_done, any_key} !== 3'b000) begin
      n_fails++; $display("FAIL reset_flags: got ack/done/any=%b expected 000", {cpu_ack, scan_done, any_key});
    end
    n_checks++;
    if (cpu_rdata !== 8'h00 || mat_row !== 8'h00) begin
      n_fails++; $display("FAIL reset_data: got rdata=%h row=%h expected 00/00", cpu_rdata, mat_row);
    end
    rst = 1'b0;
    cyc = -1;
    step();
    n_checks++;
    if ({cs_n, rd_n, wr_n} !== 3'b010 || ppi_addr !== 2'd3 || ppi_wdata !== 8'h8B) begin
      n_fails++; $display("FAIL init_write: got strobes=%b addr=%h data=%h expected 010/3/8b",
                          {cs_n, rd_n, wr_n}, ppi_addr, ppi_wdata);
    end
    // Reset in the middle of an access drops the strobes, with no ack
    rst = 1'b1;
    step();
    n_checks++;
    if ({cs_n, rd_n, wr_n} !== 3'b111 || cpu_ack !== 1'b0) begin
      n_fails++; $display("FAIL reset_mid_access: got strobes=%b ack=%b expected 111/0", {cs_n, rd_n, wr_n}, cpu_ack);
    end
  endtask

  task automatic test_single_key();
    logic pre_any;
    logic [7:0] exp;
    set_keys(2, 8'h20);
    scan_en = 1'b1;
    mat_col = 3'd2;
    pre_any = 1'b1;
    do_reset();
    step();
    while (!scan_done && cyc < 200) begin
      step();
      if (cyc == 59) pre_any = any_key;
    end
    n_checks++;
    if (cyc !== 60) begin
      n_fails++; $display("FAIL single_done_cycle: got %0d expected 60", cyc);
    end
    n_checks++;
    if (pre_any !== 1'b0) begin
      n_fails++; $display("FAIL single_precommit_any: got %b expected 0", pre_any);
    end
    n_checks++;
    if (mat_row !== 8'h20) begin
      n_fails++; $display("FAIL single_row_at_done: got %h expected 20", mat_row);
    end
    step();
    n_checks++;
    if (scan_done !== 1'b0) begin
      n_fails++; $display("FAIL single_done_width: got %b expected 0", scan_done);
    end
    n_checks++;
    if (any_key !== 1'b1) begin
      n_fails++; $display("FAIL single_any_key: got %b expected 1", any_key);
    end
    for (int c = 0; c < 8; c++) begin
      mat_col = 3'(c);
      #1;
      exp = (c == 2) ? 8'h20 : 8'h00;
      n_checks++;
      if (mat_row !== exp) begin
        n_fails++; $display("FAIL single_row_col%0d: got %h expected %h", c, mat_row, exp);
      end
    end
  endtask

  task automatic test_cpu_read_settle();
    set_keys(5, 8'h81);
    pc_init = 8'h5A;
    scan_en = 1'b1;
    do_reset();
    while (cyc < 4) step();
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 2'd2;
    step();
    while (!cpu_ack && cyc < 20) step();
    n_checks++;
    if (cyc !== 6) begin
      n_fails++; $display("FAIL settle_read_latency: ack at cycle %0d expected 6", cyc);
    end
    n_checks++;
    if (cpu_rdata !== 8'h5A) begin
      n_fails++; $display("FAIL settle_read_data: got %h expected 5a", cpu_rdata);
    end
    cpu_req = 1'b0;
    while (cyc < 9) step();
    n_checks++;
    if (cpu_rdata !== 8'h5A) begin
      n_fails++; $display("FAIL settle_rdata_hold: got %h expected 5a", cpu_rdata);
    end
    while (!scan_done && cyc < 200) step();
    n_checks++;
    if (cyc !== 60) begin
      n_fails++; $display("FAIL settle_done_cycle: got %0d expected 60", cyc);
    end
    mat_col = 3'd5;
    #1;
    n_checks++;
    if (mat_row !== 8'h81) begin
      n_fails++; $display("FAIL settle_row_col5: got %h expected 81", mat_row);
    end
    mat_col = 3'd0;
    #1;
    n_checks++;
    if (mat_row !== 8'h00) begin
      n_fails++; $display("FAIL settle_row_col0: got %h expected 00", mat_row);
    end
  endtask

  task automatic test_abort();
    set_keys(3, 8'h04);
    scan_en = 1'b1;
    do_reset();
    while (cyc < 32) step();
    cpu_req = 1'b1;
    cpu_we = 1'b1;
    cpu_addr = 2'd0;
    cpu_wdata = 8'h00;
    step();
    n_checks++;
    if (cs_n !== 1'b0 || wr_n !== 1'b0 || ppi_addr !== 2'd0 || ppi_wdata !== 8'h00) begin
      n_fails++; $display("FAIL abort_cpu_strobe: got cs=%b wr=%b addr=%h data=%h expected 0/0/0/00",
                          cs_n, wr_n, ppi_addr, ppi_wdata);
    end
    step();
    n_checks++;
    if (cpu_ack !== 1'b1) begin
      n_fails++; $display("FAIL abort_cpu_ack: got %b expected 1", cpu_ack);
    end
    cpu_req = 1'b0;
    step();
    n_checks++;
    if ({cs_n, rd_n, wr_n} !== 3'b010 || ppi_addr !== 2'd3 || ppi_wdata !== 8'h8B) begin
      n_fails++; $display("FAIL abort_reinit: got strobes=%b addr=%h data=%h expected 010/3/8b",
                          {cs_n, rd_n, wr_n}, ppi_addr, ppi_wdata);
    end
    while (!scan_done && cyc < 300) step();
    n_checks++;
    if (cyc !== 95) begin
      n_fails++; $display("FAIL abort_done_cycle: got %0d expected 95", cyc);
    end
    mat_col = 3'd3;
    #1;
    n_checks++;
    if (mat_row !== 8'h04) begin
      n_fails++; $display("FAIL abort_row_col3: got %h expected 04", mat_row);
    end
    mat_col = 3'd4;
    #1;
    n_checks++;
    if (mat_row !== 8'h00) begin
      n_fails++; $display("FAIL abort_row_col4: got %h expected 00", mat_row);
    end
  endtask

  task automatic test_same_cycle();
    int acks;
    set_keys(0, 8'h02);
    pc_init = 8'hC3;
    scan_en = 1'b1;
    acks = 0;
    do_reset();
    while (cyc < 6) step();
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 2'd2;
    step();
    n_checks++;
    if (cs_n !== 1'b0 || rd_n !== 1'b0 || ppi_addr !== 2'd2) begin
      n_fails++; $display("FAIL tie_cpu_first: got cs=%b rd=%b addr=%h expected 0/0/2", cs_n, rd_n, ppi_addr);
    end
    step();
    if (cpu_ack) acks++;
    n_checks++;
    if (cpu_ack !== 1'b1 || cpu_rdata !== 8'hC3) begin
      n_fails++; $display("FAIL tie_cpu_ack: got ack=%b data=%h expected 1/c3", cpu_ack, cpu_rdata);
    end
    cpu_req = 1'b0;
    step();
    n_checks++;
    if (cs_n !== 1'b0 || rd_n !== 1'b0 || ppi_addr !== 2'd1) begin
      n_fails++; $display("FAIL tie_scan_next: got cs=%b rd=%b addr=%h expected 0/0/1", cs_n, rd_n, ppi_addr);
    end
    while (!scan_done && cyc < 200) begin
      step();
      if (cpu_ack) acks++;
    end
    n_checks++;
    if (cyc !== 62) begin
      n_fails++; $display("FAIL tie_done_cycle: got %0d expected 62", cyc);
    end
    n_checks++;
    if (acks !== 1) begin
      n_fails++; $display("FAIL tie_ack_count: got %0d expected 1", acks);
    end
    mat_col = 3'd0;
    #1;
    n_checks++;
    if (mat_row !== 8'h02) begin
      n_fails++; $display("FAIL tie_row_col0: got %h expected 02", mat_row);
    end
  endtask

  task automatic test_scan_disabled();
    int strobes;
    int dones;
    set_keys(1, 8'hFF);
    pc_init = 8'h00;
    scan_en = 1'b0;
    strobes = 0;
    dones = 0;
    do_reset();
    step();
    n_checks++;
    if (cs_n !== 1'b0 || ppi_addr !== 2'd3 || ppi_wdata !== 8'h8B) begin
      n_fails++; $display("FAIL dis_init: got cs=%b addr=%h data=%h expected 0/3/8b", cs_n, ppi_addr, ppi_wdata);
    end
    while (cyc < 20) begin
      step();
      if (cyc >= 2 && !cs_n) strobes++;
      if (scan_done) dones++;
    end
    n_checks++;
    if (strobes !== 0) begin
      n_fails++; $display("FAIL dis_no_scan_strobes: got %0d expected 0", strobes);
    end
    cpu_req = 1'b1;
    cpu_we = 1'b1;
    cpu_addr = 2'd2;
    cpu_wdata = 8'h3C;
    step();
    while (!cpu_ack && cyc < 40) step();
    n_checks++;
    if (cyc !== 22) begin
      n_fails++; $display("FAIL dis_write_latency: ack at cycle %0d expected 22", cyc);
    end
    // Request stays asserted through the ack: next grant must wait a cycle
    cpu_we = 1'b0;
    step();
    n_checks++;
    if (cs_n !== 1'b1) begin
      n_fails++; $display("FAIL dis_no_grant_in_ack: got cs=%b expected 1", cs_n);
    end
    step();
    n_checks++;
    if (cs_n !== 1'b0 || rd_n !== 1'b0 || ppi_addr !== 2'd2) begin
      n_fails++; $display("FAIL dis_second_strobe: got cs=%b rd=%b addr=%h expected 0/0/2", cs_n, rd_n, ppi_addr);
    end
    step();
    n_checks++;
    if (cpu_ack !== 1'b1 || cpu_rdata !== 8'h3C) begin
      n_fails++; $display("FAIL dis_read_back: got ack=%b data=%h expected 1/3c", cpu_ack, cpu_rdata);
    end
    cpu_req = 1'b0;
    strobes = 0;
    repeat (60) begin
      step();
      if (!cs_n) strobes++;
      if (scan_done) dones++;
    end
    n_checks++;
    if (strobes !== 0 || dones !== 0) begin
      n_fails++; $display("FAIL dis_idle: got strobes=%0d dones=%0d expected 0/0", strobes, dones);
    end
    n_checks++;
    if (any_key !== 1'b0) begin
      n_fails++; $display("FAIL dis_any_key: got %b expected 0", any_key);
    end
  endtask

  initial begin
    rst = 1'b1;
    scan_en = 1'b0;
    cpu_req = 1'b0;
    cpu_we = 1'b0;
    cpu_addr = 2'd0;
    cpu_wdata = 8'h00;
    mat_col = 3'd0;
    pc_init = 8'h5A;
    for (int c = 0; c < 8; c++) keys[c] = 8'h00;
    test_reset();
    test_single_key();
    test_cpu_read_settle();
    test_abort();
    test_same_cycle();
    test_scan_disabled();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
